// File: rtl/serial_paralelo_lane_if.sv
// Serial lane receive bundle: bit-serial input toward the receiver, byte/valid/lock status back out.
interface serial_paralelo_lane_if;
    logic       data_paralelo_serial;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_serial_paralelo;

    modport master (
        output data_paralelo_serial,
        input  data_out,
        input  valid_out,
        input  active_serial_paralelo
    );

    modport slave (
        input  data_paralelo_serial,
        output data_out,
        output valid_out,
        output active_serial_paralelo
    );
endinterface

// File: rtl/serial_paralelo_lane.sv
// Per-lane serial-to-parallel receiver: bit-granular comma hunt, lock after BC_LOCK aligned commas,
// then one-cycle valid pulses for every non-comma byte.
module serial_paralelo_lane #(
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int unsigned BC_LOCK = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    serial_paralelo_lane_if.slave lane
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BC_W   = 4;
    localparam logic [BC_W-1:0]  LOCK_CNT = BC_W'(BC_LOCK);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   sr_q;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]     bc_cnt_q, bc_cnt_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                active_q, active_d;

    logic [BYTE_W-1:0]   window_c;
    logic                comma_c;
    logic                boundary_c;
    logic [BC_W-1:0]     bc_inc_c;

    // Byte completed by the bit arriving at this edge
    assign window_c   = {sr_q[BYTE_W-2:0], lane.data_paralelo_serial};
    assign comma_c    = (window_c == COMMA);
    assign boundary_c = (bit_cnt_q == LAST_BIT);
    assign bc_inc_c   = bc_cnt_q + BC_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        active_d  = active_q;

        case (state_q)
            SEARCH: begin
                bit_cnt_d = bit_cnt_q;
                if (comma_c) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = BC_W'(1);
                    if (BC_LOCK == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary_c) begin
                    if (comma_c) begin
                        bc_cnt_d = bc_inc_c;
                        if (bc_inc_c == LOCK_CNT) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Misaligned byte drops the hunt; this byte is not rescanned
                        state_d  = SEARCH;
                        bc_cnt_d = '0;
                    end
                end
            end

            ACTIVE: begin
                // Alignment is frozen; commas are idle fill and never reach the output
                if (boundary_c && !comma_c) begin
                    data_d  = window_c;
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= window_c;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign lane.data_out               = data_q;
    assign lane.valid_out              = valid_q;
    assign lane.active_serial_paralelo = active_q;

endmodule

// File: tb/tb_serial_paralelo_lane.sv
// Bench for serial_paralelo_lane: directed lock/data/reset scenarios plus random traffic,
// all checked every cycle against a bit-history reference model.
module tb_serial_paralelo_lane;

    localparam logic [7:0] COMMA   = 8'hBC;
    localparam int         BC_LOCK = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_lane_if lane_if ();

    serial_paralelo_lane #(
        .COMMA   (COMMA),
        .BC_LOCK (BC_LOCK)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .lane    (lane_if.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bit history since reset, lock anchored at the edge index of the first comma
    bit         hist[$];
    int         n_edge;
    int         anchor;
    int         commas;
    int         mode;      // 0 hunting, 1 counting commas, 2 locked
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;
    logic [7:0] pulse_q[$];

    task automatic model_step(input logic b, input logic r);
        logic [7:0] byte_v;
        if (r) begin
            hist.delete();
            repeat (8) hist.push_back(1'b0);
            n_edge   = 0;
            anchor   = 0;
            commas   = 0;
            mode     = 0;
            m_data   = 8'h00;
            m_valid  = 1'b0;
            m_active = 1'b0;
        end else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            n_edge++;
            byte_v = 8'h00;
            for (int i = 0; i < 8; i++) byte_v = {byte_v[6:0], hist[i]};
            m_valid = 1'b0;
            if (mode == 0) begin
                if (byte_v == COMMA) begin
                    anchor = n_edge;
                    commas = 1;
                    if (commas == BC_LOCK) begin
                        mode     = 2;
                        m_active = 1'b1;
                    end else begin
                        mode = 1;
                    end
                end
            end else if (((n_edge - anchor) % 8) == 0) begin
                if (mode == 1) begin
                    if (byte_v == COMMA) begin
                        commas++;
                        if (commas == BC_LOCK) begin
                            mode     = 2;
                            m_active = 1'b1;
                        end
                    end else begin
                        mode   = 0;
                        commas = 0;
                    end
                end else if (byte_v != COMMA) begin
                    m_data  = byte_v;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic r);
        @(negedge clk_32f);
        lane_if.data_paralelo_serial = b;
        reset = r;
        @(posedge clk_32f);
        model_step(b, r);
        #1;
        check("data", lane_if.data_out, m_data);
        check("valid", 8'(lane_if.valid_out), 8'(m_valid));
        check("active", 8'(lane_if.active_serial_paralelo), 8'(m_active));
        if (lane_if.valid_out === 1'b1) pulse_q.push_back(lane_if.data_out);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] v;
        int         op;
        c = COMMA;
        lane_if.data_paralelo_serial = 1'b0;

        // Reset with random bits on the line
        repeat (3) send_bit(1'($urandom_range(0, 1)), 1'b1);

        // Lock with 3-bit misalignment; 4th comma ends on bit 35
        pulse_q.delete();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (3) send_byte(COMMA);
        for (int i = 7; i >= 1; i--) send_bit(c[i], 1'b0);
        check("prelock", 8'(lane_if.active_serial_paralelo), 8'd0);
        send_bit(c[0], 1'b0);
        check("lock35", 8'(lane_if.active_serial_paralelo), 8'd1);
        repeat (3) send_byte(COMMA);
        check("comma_npulse", 8'(pulse_q.size()), 8'd0);

        // Data delivery with a comma slot
        pulse_q.delete();
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'hBC);
        send_byte(8'hFF);
        check("data_npulse", 8'(pulse_q.size()), 8'd3);
        if (pulse_q.size() == 3) begin
            check("pulse0", pulse_q[0], 8'hAA);
            check("pulse1", pulse_q[1], 8'h55);
            check("pulse2", pulse_q[2], 8'hFF);
        end

        // Lock abort then relock
        send_bit(1'b0, 1'b1);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h12);
        check("abort", 8'(lane_if.active_serial_paralelo), 8'd0);
        repeat (3) send_byte(COMMA);
        check("relock_pre", 8'(lane_if.active_serial_paralelo), 8'd0);
        send_byte(COMMA);
        check("relock", 8'(lane_if.active_serial_paralelo), 8'd1);

        // Reset at bit 4 of a data byte while active
        pulse_q.delete();
        v = 8'h3C;
        for (int i = 7; i >= 4; i--) send_bit(v[i], 1'b0);
        send_bit(v[3], 1'b1);
        check("rst_active", 8'(lane_if.active_serial_paralelo), 8'd0);
        check("rst_valid", 8'(lane_if.valid_out), 8'd0);
        check("rst_data", lane_if.data_out, 8'h00);
        for (int i = 2; i >= 0; i--) send_bit(v[i], 1'b0);
        repeat (3) send_byte(COMMA);
        check("rst_nolock", 8'(lane_if.active_serial_paralelo), 8'd0);
        send_byte(COMMA);
        check("rst_lock", 8'(lane_if.active_serial_paralelo), 8'd1);
        check("rst_npulse", 8'(pulse_q.size()), 8'd0);

        // Straddling comma pattern must not realign
        pulse_q.delete();
        send_byte(8'h0B);
        send_byte(8'hC0);
        send_byte(8'hAA);
        check("noalign_npulse", 8'(pulse_q.size()), 8'd3);
        if (pulse_q.size() == 3) begin
            check("noalign0", pulse_q[0], 8'h0B);
            check("noalign1", pulse_q[1], 8'hC0);
            check("noalign2", pulse_q[2], 8'hAA);
        end

        // Random traffic: commas, data, bit slips and occasional resets
        for (int k = 0; k < 400; k++) begin
            op = int'($urandom_range(0, 99));
            if (op < 45)      send_byte(COMMA);
            else if (op < 85) send_byte(8'($urandom));
            else if (op < 96) send_bit(1'($urandom_range(0, 1)), 1'b0);
            else              send_bit(1'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
